// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port synchronous RAM, first-word-fall-through read.
// Define FIFO_CTRL_COUNT_EN to add the registered occupancy output 'count'.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef FIFO_CTRL_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  // Handshake: wr_en is a push request, taken when not full (or when a pop frees a slot
  // in the same cycle); rd_en is a pop request, taken when not empty. A refused request
  // is dropped, not held, and is reported by a one-cycle overflow/underflow pulse.
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] rd_ptr_inc;
  logic                  push_acc;
  logic                  pop_acc;

  assign wr_ptr_inc = wr_ptr + ADDR_WIDTH'(1);
  assign rd_ptr_inc = rd_ptr + ADDR_WIDTH'(1);

  assign push_acc = wr_en & (~full | rd_en);
  assign pop_acc  = rd_en & ~empty;

  assign ram_we     = push_acc;
  assign ram_addr_a = wr_ptr;
  assign ram_din_a  = wr_data;
  // Read address runs one ahead on a pop so the next head is ready the following cycle.
  assign ram_addr_b = pop_acc ? rd_ptr_inc : rd_ptr;
  assign rd_data    = ram_dout_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr_inc;
      if (pop_acc)  rd_ptr <= rd_ptr_inc;
      overflow  <= wr_en & ~push_acc;
      underflow <= rd_en & ~pop_acc;
      case ({push_acc, pop_acc})
        2'b10: begin
          empty <= 1'b0;
          full  <= (wr_ptr_inc == rd_ptr);
        end
        2'b01: begin
          full  <= 1'b0;
          empty <= (rd_ptr_inc == wr_ptr);
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_CTRL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with an 8x8 synchronous dual-port RAM model and a data scoreboard.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
  logic       ram_we;
  logic [2:0] ram_addr_a;
  logic [7:0] ram_din_a;
  logic [2:0] ram_addr_b;
  logic [7:0] ram_dout_b;
`ifdef FIFO_CTRL_COUNT_EN
  logic [3:0] count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  fifo_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .ram_we     (ram_we),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
`ifdef FIFO_CTRL_COUNT_EN
    ,
    .count      (count)
`endif
  );

  // RAM model: synchronous write, registered read address.
  logic [7:0] mem [8];
  logic [2:0] addr_b_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_din_a;
    addr_b_q <= ram_addr_b;
  end
  assign ram_dout_b = mem[addr_b_q];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every accepted pop must present the oldest expected entry
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_data: pop with empty scoreboard, got 0x%0h at %0t", rd_data, $time);
      end else begin
        check("pop_data", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // driver: one clock cycle of stimulus; q marks a push the bench expects to be accepted
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic q);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    if (q) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic pop();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    #3;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_underflow", {31'b0, underflow}, 32'd0);
`ifdef FIFO_CTRL_COUNT_EN
    check("rst_count", {28'b0, count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // single push then pop
    push(8'h11);
    check("fwft_empty", {31'b0, empty}, 32'd0);
    check("fwft_data", {24'b0, rd_data}, 32'h11);
    pop();
    check("pop_empty", {31'b0, empty}, 32'd1);

    // fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      push(8'(i));
      if (i == 6) check("full_at_7", {31'b0, full}, 32'd0);
    end
    check("full_at_8", {31'b0, full}, 32'd1);
`ifdef FIFO_CTRL_COUNT_EN
    check("count_full", {28'b0, count}, 32'd8);
`endif
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    check("overflow_pulse", {31'b0, overflow}, 32'd1);
    check("overflow_full", {31'b0, full}, 32'd1);
    idle();
    check("overflow_clear", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) pop();
    check("drain_empty", {31'b0, empty}, 32'd1);
    check("drain_full", {31'b0, full}, 32'd0);

    // 20 push/pop pairs, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h20 + i));
      pop();
    end
    check("pairs_empty", {31'b0, empty}, 32'd1);
    check("pairs_scoreboard", exp_q.size(), 32'd0);

    // full with simultaneous push and pop; pointers both at 5 here
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    check("fill2_full", {31'b0, full}, 32'd1);
    wr_en = 1'b1; wr_data = 8'hAA; rd_en = 1'b1;
    exp_q.push_back(8'hAA);
    #1;
    check("ram_we_fullpp", {31'b0, ram_we}, 32'd1);
    check("ram_addr_a_fullpp", {29'b0, ram_addr_a}, 32'd5);
    check("ram_addr_b_fullpp", {29'b0, ram_addr_b}, 32'd6);
    @(posedge clk);
    #1 wr_en = 1'b0; rd_en = 1'b0;
    check("fullpp_full", {31'b0, full}, 32'd1);
    check("fullpp_head", {24'b0, rd_data}, 32'h41);
    for (int i = 0; i < 8; i++) pop();
    check("fullpp_drain_empty", {31'b0, empty}, 32'd1);

    // underflow cases
    pop();
    check("underflow_pulse", {31'b0, underflow}, 32'd1);
    idle();
    check("underflow_clear", {31'b0, underflow}, 32'd0);
    drive(1'b1, 8'h5C, 1'b1, 1'b1);
    check("pushpop_empty_uf", {31'b0, underflow}, 32'd1);
    check("pushpop_empty_empty", {31'b0, empty}, 32'd0);
    check("pushpop_empty_data", {24'b0, rd_data}, 32'h5C);
    pop();
    check("pushpop_drain_empty", {31'b0, empty}, 32'd1);

    // asynchronous reset in the middle of a cycle
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("pre_reset_empty", {31'b0, empty}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_empty", {31'b0, empty}, 32'd1);
    check("async_rst_full", {31'b0, full}, 32'd0);
`ifdef FIFO_CTRL_COUNT_EN
    check("async_rst_count", {28'b0, count}, 32'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    push(8'h77);
    check("post_reset_data", {24'b0, rd_data}, 32'h77);
    pop();
    check("post_reset_empty", {31'b0, empty}, 32'd1);
    check("final_scoreboard", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the pointer width; capacity is 2**ADDR_WIDTH entries.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of one entry.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1, push request.
REQ-006 The block SHALL have port wr_data, input, DATA_WIDTH, push data.
REQ-007 The block SHALL have port rd_en, input, 1, pop request.
REQ-008 The block SHALL have port rd_data, output, DATA_WIDTH, head entry in first-word-fall-through form.
REQ-009 The block SHALL have port full, output, 1, high when the FIFO holds 2**ADDR_WIDTH entries.
REQ-010 The block SHALL have port empty, output, 1, high when the FIFO holds 0 entries.
REQ-011 The block SHALL have port overflow, output, 1, one-cycle pulse flagging a rejected push.
REQ-012 The block SHALL have port underflow, output, 1, one-cycle pulse flagging a rejected pop.
REQ-013 The block SHALL have port ram_we, output, 1, write enable to the dual-port synchronous RAM.
REQ-014 The block SHALL have port ram_addr_a, output, ADDR_WIDTH, RAM write address.
REQ-015 The block SHALL have port ram_din_a, output, DATA_WIDTH, RAM write data.
REQ-016 The block SHALL have port ram_addr_b, output, ADDR_WIDTH, RAM read address; the RAM registers it.
REQ-017 The block SHALL have port ram_dout_b, input, DATA_WIDTH, RAM read data, which is RAM[registered ram_addr_b].

Function
REQ-018 A push SHALL be accepted when wr_en=1 and (full=0 or rd_en=1); a pop SHALL be accepted when rd_en=1 and empty=0.
REQ-019 ram_we SHALL equal the push-accept term combinationally, ram_addr_a SHALL equal wr_ptr, and ram_din_a SHALL equal wr_data.
REQ-020 ram_addr_b SHALL equal rd_ptr+1 (mod 2**ADDR_WIDTH) when a pop is accepted, else rd_ptr; rd_data SHALL equal ram_dout_b.
REQ-021 rd_data SHALL present the head entry in the cycle after it was written, or in the cycle after the preceding pop; rd_data is don't-care while empty=1.
REQ-022 wr_ptr and rd_ptr SHALL each increment by one per accepted push or pop and wrap from 2**ADDR_WIDTH-1 to 0.
REQ-023 full and empty SHALL be registered: push only -> empty<=0, full<=(wr_ptr+1==rd_ptr); pop only -> full<=0, empty<=(rd_ptr+1==wr_ptr); both or neither -> flags unchanged.
REQ-024 Push with empty=1 and rd_en=1 SHALL be accepted; the pop SHALL be rejected and underflow SHALL pulse.
REQ-025 Push and pop with full=1 SHALL both be accepted; full SHALL remain 1.
REQ-026 overflow SHALL be 1 in the cycle after wr_en=1 was rejected (full=1, rd_en=0), else 0; underflow likewise for a rejected rd_en.
REQ-027 A rejected operation SHALL change no pointer, flag, or RAM content.

Reset
REQ-028 reset=1 SHALL immediately set wr_ptr=0, rd_ptr=0, empty=1, full=0, overflow=0, underflow=0 (and count=0 when present), regardless of clk.
REQ-029 RAM contents SHALL NOT be cleared by reset; a push in flight when reset asserts SHALL be lost.
REQ-030 Operation SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-031 With macro FIFO_CTRL_COUNT_EN defined, the block SHALL add output count (ADDR_WIDTH+1 bits, reset 0, registered), +1 per push-only cycle and -1 per pop-only cycle, and unchanged otherwise.
REQ-032 Without FIFO_CTRL_COUNT_EN, port count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (ADDR_WIDTH=3, DATA_WIDTH=8, block connected to an 8x8 dual-port synchronous RAM)
REQ-033 After reset, push 0x11 -> next cycle empty=0 and rd_data=0x11; pop -> next cycle empty=1.
REQ-034 Push 0x00..0x07 -> full=1 after the 8th push; a 9th push of 0xFF -> overflow=1 for one cycle, and pops then return 0x00..0x07 in order.
REQ-035 Run 20 push/pop pairs with data 0x20..0x33 -> pointers wrap and data emerges in order with no loss.
REQ-036 Full, push 0xAA with pop in the same cycle -> full stays 1, the popped value is the oldest entry, and 0xAA is popped last.
REQ-037 Empty, pop alone -> underflow=1 for one cycle; pop together with push 0x5C -> underflow=1 and next cycle rd_data=0x5C with empty=0.
REQ-038 Push 3 entries, assert reset mid-cycle asynchronously -> empty=1, full=0 (and count=0 with FIFO_CTRL_COUNT_EN) before the next clk edge.
